// File: rtl/demux1to3_buf.sv
// demux1to3_buf: registered 1-to-3 steering stage.
// One input word per cycle (valid/ready) is steered by a 2-bit select into one
// of three one-entry output buffers. Each channel drains independently, so a
// stalled consumer only blocks words addressed to its own channel. Select
// value 3 is illegal: the word is consumed, dropped, and sel_err pulses for one cycle.
// Optional feature macro: DEMUX_SEL_ERR_CNT_EN adds a saturating 16-bit
// err_count output that counts dropped illegal-select words.
module demux1to3_buf #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             sel,
  input  logic [WORD_LENGTH-1:0] Data_In,
  output logic                   out_valid_0,
  output logic                   out_valid_1,
  output logic                   out_valid_2,
  input  logic                   out_ready_0,
  input  logic                   out_ready_1,
  input  logic                   out_ready_2,
  output logic [WORD_LENGTH-1:0] Data_0,
  output logic [WORD_LENGTH-1:0] Data_1,
  output logic [WORD_LENGTH-1:0] Data_2,
  output logic                   sel_err
`ifdef DEMUX_SEL_ERR_CNT_EN
  ,
  output logic [15:0]            err_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t             state_p0 [3];
  buf_state_t             state_d  [3];
  logic [WORD_LENGTH-1:0] data_p0  [3];
  logic [2:0]             out_ready_v;
  logic [2:0]             fill;
  logic [2:0]             drain;
  logic                   accept;
  logic                   illegal;
  logic                   sel_err_p0;

  assign out_ready_v = {out_ready_2, out_ready_1, out_ready_0};

  // Ready for the addressed channel, transfer decode and per-channel next state.
  always_comb begin
    in_ready = 1'b1;
    fill     = 3'b000;
    drain    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      state_d[k] = state_p0[k];
    end
    // A full buffer can take a new word only when its old word leaves this edge.
    case (sel)
      2'd0:    in_ready = (state_p0[0] == EMPTY) || out_ready_v[0];
      2'd1:    in_ready = (state_p0[1] == EMPTY) || out_ready_v[1];
      2'd2:    in_ready = (state_p0[2] == EMPTY) || out_ready_v[2];
      default: in_ready = 1'b1;
    endcase
    accept  = in_valid && in_ready;
    illegal = accept && (sel == 2'd3);
    for (int k = 0; k < 3; k++) begin
      fill[k]  = accept && (sel == 2'(k));
      drain[k] = (state_p0[k] == FULL) && out_ready_v[k];
      // A fill wins over a same-edge drain: the buffer stays FULL with the new word.
      if (fill[k]) begin
        state_d[k] = FULL;
      end else if (drain[k]) begin
        state_d[k] = EMPTY;
      end
    end
  end

  // Channel buffer state registers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        state_p0[k] <= EMPTY;
      end else begin
        state_p0[k] <= state_d[k];
      end
    end
  end

  // Channel data registers: load only on a fill, otherwise hold the last word.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        data_p0[k] <= '0;
      end else if (fill[k]) begin
        data_p0[k] <= Data_In;
      end
    end
  end

  // One-cycle pulse after an illegal-select word is consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_err_p0 <= 1'b0;
    end else begin
      sel_err_p0 <= illegal;
    end
  end

`ifdef DEMUX_SEL_ERR_CNT_EN
  logic [15:0] err_cnt_p0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating count of dropped illegal-select words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_p0 <= '0;
    end else if (illegal) begin
      err_cnt_p0 <= sat_inc16(err_cnt_p0);
    end
  end

  assign err_count = err_cnt_p0;
`endif

  assign out_valid_0 = (state_p0[0] == FULL);
  assign out_valid_1 = (state_p0[1] == FULL);
  assign out_valid_2 = (state_p0[2] == FULL);
  assign Data_0      = data_p0[0];
  assign Data_1      = data_p0[1];
  assign Data_2      = data_p0[2];
  assign sel_err     = sel_err_p0;

endmodule

// File: tb/tb_demux1to3_buf.sv
// Testbench for demux1to3_buf: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
// Build with DEMUX_SEL_ERR_CNT_EN defined to also cover err_count.
module tb_demux1to3_buf;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [31:0] Data_In;
  logic [2:0]  ordy;
  logic        out_valid_0, out_valid_1, out_valid_2;
  logic [31:0] Data_0, Data_1, Data_2;
  logic        sel_err;
`ifdef DEMUX_SEL_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  demux1to3_buf #(.WORD_LENGTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel         (sel),
    .Data_In     (Data_In),
    .out_valid_0 (out_valid_0),
    .out_valid_1 (out_valid_1),
    .out_valid_2 (out_valid_2),
    .out_ready_0 (ordy[0]),
    .out_ready_1 (ordy[1]),
    .out_ready_2 (ordy[2]),
    .Data_0      (Data_0),
    .Data_1      (Data_1),
    .Data_2      (Data_2),
    .sel_err     (sel_err)
`ifdef DEMUX_SEL_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each channel is a one-word slot (valid flag + word).
  logic        m_valid [3];
  logic [31:0] m_data  [3];
  logic        m_err;
  logic [15:0] m_cnt;

  function automatic logic model_ready();
    if (sel == 2'd3) return 1'b1;
    return !m_valid[sel] || ordy[sel];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        m_valid[k] <= 1'b0;
        m_data[k]  <= 32'h0;
      end
      m_err <= 1'b0;
      m_cnt <= 16'h0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (in_valid && model_ready() && sel == 2'(k)) begin
          m_valid[k] <= 1'b1;
          m_data[k]  <= Data_In;
        end else if (m_valid[k] && ordy[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
      m_err <= in_valid && (sel == 2'd3);
      if (in_valid && sel == 2'd3 && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
    end
  end

  // Compare process: all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    #2;
    if (check_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
      chk("out_valid_0", {31'b0, out_valid_0}, {31'b0, m_valid[0]});
      chk("out_valid_1", {31'b0, out_valid_1}, {31'b0, m_valid[1]});
      chk("out_valid_2", {31'b0, out_valid_2}, {31'b0, m_valid[2]});
      chk("Data_0", Data_0, m_data[0]);
      chk("Data_1", Data_1, m_data[1]);
      chk("Data_2", Data_2, m_data[2]);
      chk("sel_err", {31'b0, sel_err}, {31'b0, m_err});
`ifdef DEMUX_SEL_ERR_CNT_EN
      chk("err_count", {16'b0, err_count}, {16'b0, m_cnt});
`endif
    end
  end

  task automatic drive(input logic rst_n, input logic v, input logic [1:0] s,
                       input logic [31:0] d, input logic [2:0] r);
    @(negedge clk);
    reset    = rst_n;
    in_valid = v;
    sel      = s;
    Data_In  = d;
    ordy     = r;
    #3;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; sel = 2'd0; Data_In = 32'h0; ordy = 3'b000;

    // Reset held two cycles while a word is offered: nothing may be stored.
    drive(1'b0, 1'b1, 2'd0, 32'hDEAD, 3'b000);
    drive(1'b0, 1'b1, 2'd0, 32'hDEAD, 3'b000);
    drive(1'b1, 1'b0, 2'd0, 32'h0, 3'b000);
    check_en = 1'b1;
    chk("rst_valid", {29'b0, out_valid_2, out_valid_1, out_valid_0}, 32'h0);
    chk("rst_d0", Data_0, 32'h0);
    chk("rst_d1", Data_1, 32'h0);
    chk("rst_d2", Data_2, 32'h0);
    chk("rst_sel_err", {31'b0, sel_err}, 32'h0);

    // Steering to each channel with all consumers stalled.
    drive(1'b1, 1'b1, 2'd0, 32'h11, 3'b000);
    drive(1'b1, 1'b1, 2'd1, 32'h22, 3'b000);
    drive(1'b1, 1'b1, 2'd2, 32'h33, 3'b000);
    drive(1'b1, 1'b1, 2'd1, 32'h66, 3'b000);
    chk("steer_d0", Data_0, 32'h11);
    chk("steer_d1", Data_1, 32'h22);
    chk("steer_d2", Data_2, 32'h33);
    chk("steer_valid", {29'b0, out_valid_2, out_valid_1, out_valid_0}, 32'h7);
    chk("steer_full_ready", {31'b0, in_ready}, 32'h0);

    // Channel 2 streams one word per cycle while channel 0 stays stalled.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd2, 32'h100 + i, 3'b100);
      chk("stream_ready", {31'b0, in_ready}, 32'h1);
    end
    drive(1'b1, 1'b0, 2'd0, 32'h0, 3'b000);
    chk("stream_d2", Data_2, 32'h102);
    chk("stream_d0_hold", Data_0, 32'h11);

    // Drain and refill channel 1 on the same edge.
    drive(1'b1, 1'b1, 2'd1, 32'h44, 3'b010);
    chk("drainfill_ready", {31'b0, in_ready}, 32'h1);
    drive(1'b1, 1'b0, 2'd0, 32'h0, 3'b000);
    chk("drainfill_d1", Data_1, 32'h44);
    chk("drainfill_v1", {31'b0, out_valid_1}, 32'h1);

    // Illegal select with every channel full and stalled.
    drive(1'b1, 1'b1, 2'd3, 32'h55, 3'b000);
    chk("illegal_ready", {31'b0, in_ready}, 32'h1);
    drive(1'b1, 1'b0, 2'd0, 32'h0, 3'b000);
    chk("illegal_pulse", {31'b0, sel_err}, 32'h1);
    chk("illegal_d0", Data_0, 32'h11);
    chk("illegal_d1", Data_1, 32'h44);
    chk("illegal_d2", Data_2, 32'h102);
    chk("illegal_valid", {29'b0, out_valid_2, out_valid_1, out_valid_0}, 32'h7);
`ifdef DEMUX_SEL_ERR_CNT_EN
    chk("err_count_one", {16'b0, err_count}, 32'h1);
`endif
    drive(1'b1, 1'b0, 2'd0, 32'h0, 3'b000);
    chk("illegal_pulse_end", {31'b0, sel_err}, 32'h0);

`ifdef DEMUX_SEL_ERR_CNT_EN
    // Push the counter past its ceiling.
    @(negedge clk);
    in_valid = 1'b1; sel = 2'd3; Data_In = 32'h55;
    repeat (65536) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #3;
    chk("err_count_sat", {16'b0, err_count}, 32'hFFFF);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    check_en = 1'b0;
    #4;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux1to3_buf.md
# demux1to3_buf

Registered 1-to-3 steering stage: accepts one data word per cycle on a valid/ready input and delivers it to exactly one of three output channels chosen by a 2-bit select. It is the distribution counterpart of the datapath 3-to-1 selectors, used where one producer (for example a result bus) feeds three independent consumers. Each output has its own one-entry buffer, so a stalled consumer never blocks traffic to the other two.

## Interface
- WORD_LENGTH, 32, data width of the input and all outputs
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when high with in_valid
- sel  input  2  destination: 0 → channel 0, 1 → channel 1, 2 → channel 2, 3 → illegal
- Data_In  input  WORD_LENGTH  input word
- out_valid_k (k = 0,1,2)  output  1  channel k buffer holds a word
- out_ready_k (k = 0,1,2)  input  1  consumer k takes the word this cycle
- Data_k (k = 0,1,2)  output  WORD_LENGTH  channel k buffered word
- sel_err  output  1  one-cycle pulse: an illegal-select word was consumed

## Operation
- Per channel k: two-state buffer, EMPTY (out_valid_k=0) and FULL (out_valid_k=1).
- Input transfer: in_valid && in_ready at a rising edge.
- in_ready is combinational: sel=k∈{0,1,2} → in_ready = !out_valid_k || out_ready_k; sel=3 → in_ready = 1.
- Transfer with sel=k: Data_k ← Data_In, out_valid_k ← 1 (EMPTY→FULL, or FULL→FULL when the old word drains on the same edge).
- Output transfer on channel k: out_valid_k && out_ready_k. With no simultaneous refill, FULL→EMPTY.
- Channels are independent: any combination of drains and at most one fill happens on the same edge.
- Transfer with sel=3: word discarded, no channel changes, sel_err=1 on the following cycle for one cycle.
- Data_k holds its last value while EMPTY; it changes only on a fill of channel k. out_valid_k never drops without an output transfer.
- sel and Data_In are sampled only on an input transfer; changes while in_valid=1 and in_ready=0 are permitted.

## Timing
- Latency: word accepted at edge N is visible on Data_k with out_valid_k=1 from edge N.
- Throughput: one word per cycle to a channel whose consumer holds out_ready_k=1 continuously.
- Combinational paths: sel, in_valid-independent → in_ready; out_ready_k → in_ready. No combinational path from inputs to out_valid_k, Data_k or sel_err.
- Reset (reset=0 at an edge): all out_valid_k=0, all Data_k=0, sel_err=0, error counter=0; any buffered words are discarded. in_ready follows its equation (high for an empty channel) once reset is released; during reset, input transfers are ignored.
- Reset asserted mid-transfer: reset wins; no word is stored.

## Configuration
- DEMUX_SEL_ERR_CNT_EN defined: adds output err_count [15:0], which increments on every sel=3 transfer, saturates at 16'hFFFF, and is reset to 0. sel_err pulse unchanged.
- Undefined: err_count port and counter absent; sel_err still generated.

## Test plan
- Reset: hold reset=0 2 cycles with in_valid=1, sel=0, Data_In=32'hDEAD → after release out_valid_0/1/2=0, Data_0/1/2=0, sel_err=0.
- Steering: send 32'h11 sel=0, 32'h22 sel=1, 32'h33 sel=2 on consecutive cycles, all out_ready=0 → Data_0=11, Data_1=22, Data_2=33, all valid; fourth word with sel=1 sees in_ready=0.
- Independence/backpressure: channel 0 FULL, out_ready_0=0; words to sel=2 with out_ready_2=1 stream at one per cycle; Data_0 stays 32'h11.
- Simultaneous drain and fill: channel 1 FULL (32'h22), out_ready_1=1, in_valid=1 sel=1 Data_In=32'h44 → in_ready=1; next cycle Data_1=32'h44, out_valid_1=1.
- Illegal select: sel=3, Data_In=32'h55, all channels FULL and stalled → in_ready=1, sel_err=1 one cycle, no channel changes; with DEMUX_SEL_ERR_CNT_EN, err_count=1, and after 65536 more illegal words err_count=16'hFFFF.
